// File: rtl/multdiv_pkg.sv
// Shared definitions for the multdiv unit: divider FSM states, default operand
// width, iteration-counter sizing and the most-negative operand constant.
package multdiv_pkg;

    localparam int DIV_WIDTH = 32;

    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

    localparam int CNT_W = cnt_width(DIV_WIDTH);

    localparam logic [DIV_WIDTH-1:0] MOST_NEG = {1'b1, {(DIV_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/twos_negate.sv
// Combinational two's-complement negation, used for operand magnitudes and the
// final quotient sign correction.
module twos_negate #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] y
);

    assign y = ~a + {{(WIDTH-1){1'b0}}, 1'b1};

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed restoring divider: one quotient bit per cycle, zero-divisor
// exception, registered quotient with a single-cycle ready pulse.
module seq_divider
    import multdiv_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int CW = cnt_width(WIDTH);

    div_state_e       state_r;
    div_state_e       state_next_s;
    logic [WIDTH:0]   rem_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] div_r;
    logic             sign_r;
    logic [CW-1:0]    cnt_r;

    logic [WIDTH-1:0] neg_a_s;
    logic [WIDTH-1:0] neg_b_s;
    logic [WIDTH-1:0] neg_q_s;
    logic [WIDTH-1:0] abs_a_s;
    logic [WIDTH-1:0] abs_b_s;
    logic [WIDTH+1:0] trial_s;
    logic             last_step_s;
    logic             zero_div_s;
    logic             start_zero_s;

    twos_negate #(.WIDTH(WIDTH)) u_neg_a (.a(data_operandA), .y(neg_a_s));
    twos_negate #(.WIDTH(WIDTH)) u_neg_b (.a(data_operandB), .y(neg_b_s));
    twos_negate #(.WIDTH(WIDTH)) u_neg_q (.a(quo_r),         .y(neg_q_s));

    // The magnitude of the most-negative value is 2^(WIDTH-1), exact as unsigned.
    assign abs_a_s = data_operandA[WIDTH-1] ? neg_a_s : data_operandA;
    assign abs_b_s = data_operandB[WIDTH-1] ? neg_b_s : data_operandB;

    // Trial subtract on the shifted remainder; the extra top bit is the borrow.
    assign trial_s      = {rem_r, quo_r[WIDTH-1]} - {2'b00, div_r};
    assign last_step_s  = (cnt_r == CW'(WIDTH - 1));
    assign zero_div_s   = ~|div_r;
    assign start_zero_s = ~|abs_b_s;

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; a new request restarts from any state.
    always_comb begin
        state_next_s = state_r;
        if (ctrl_DIV) begin
            state_next_s = start_zero_s ? DONE : RUN;
        end else begin
            case (state_r)
                IDLE:    state_next_s = IDLE;
                RUN:     state_next_s = last_step_s ? DONE : RUN;
                DONE:    state_next_s = IDLE;
                default: state_next_s = IDLE;
            endcase
        end
    end

    // Operand capture and one restoring-division step per RUN cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rem_r  <= {(WIDTH+1){1'b0}};
            quo_r  <= {WIDTH{1'b0}};
            div_r  <= {WIDTH{1'b0}};
            sign_r <= 1'b0;
            cnt_r  <= {CW{1'b0}};
        end else if (ctrl_DIV) begin
            rem_r  <= {(WIDTH+1){1'b0}};
            quo_r  <= abs_a_s;
            div_r  <= abs_b_s;
            sign_r <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            cnt_r  <= {CW{1'b0}};
        end else if (state_r == RUN) begin
            cnt_r <= cnt_r + CW'(1);
            if (!trial_s[WIDTH+1]) begin
                rem_r <= trial_s[WIDTH:0];
                quo_r <= {quo_r[WIDTH-2:0], 1'b1};
            end else begin
                rem_r <= {rem_r[WIDTH-1:0], quo_r[WIDTH-1]};
                quo_r <= {quo_r[WIDTH-2:0], 1'b0};
            end
        end
    end

    // Registered outputs; result and exception hold until the next completion.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data_result    <= {WIDTH{1'b0}};
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            if (ctrl_DIV) begin
                busy <= 1'b1;
            end else if (state_r == DONE) begin
                data_result    <= zero_div_s ? {WIDTH{1'b0}} : (sign_r ? neg_q_s : quo_r);
                data_exception <= zero_div_s;
                data_resultRDY <= 1'b1;
                busy           <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider: vector table plus hand-written
// back-to-back, restart and mid-operation reset sequences.
module tb_seq_divider;

    logic        clock;
    logic        reset_n;
    logic        ctrl_DIV;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int checks;
    int errors;

    seq_divider #(.WIDTH(32)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic        exc;
        int          lat;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs[NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Start one division and wait (bounded) for its ready pulse.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_q, input logic exp_exc,
                           input int exp_lat, input string name);
        int lat;
        lat = 0;
        @(negedge clock);
        ctrl_DIV = 1'b1;
        data_operandA = a;
        data_operandB = b;
        @(posedge clock);
        #1;
        ctrl_DIV = 1'b0;
        chk({name, " busy_after_start"}, {31'd0, busy}, 32'd1);
        for (int n = 1; n <= 60 && lat == 0; n++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) lat = n;
        end
        chk({name, " latency"}, 32'(lat), 32'(exp_lat));
        chk({name, " result"}, data_result, exp_q);
        chk({name, " exception"}, {31'd0, data_exception}, {31'd0, exp_exc});
        chk({name, " busy_in_rdy"}, {31'd0, busy}, 32'd0);
        @(posedge clock);
        #1;
        chk({name, " rdy_single"}, {31'd0, data_resultRDY}, 32'd0);
    endtask

    initial begin
        int lat;
        int early;
        checks = 0;
        errors = 0;

        vecs[0]  = '{32'd100,        32'd7,          32'd14,         1'b0, 33};
        vecs[1]  = '{32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   1'b0, 33};
        vecs[2]  = '{32'd100,        32'hFFFFFFF9,   32'hFFFFFFF2,   1'b0, 33};
        vecs[3]  = '{32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         1'b0, 33};
        vecs[4]  = '{32'd0,          32'd5,          32'd0,          1'b0, 33};
        vecs[5]  = '{32'd12345,      32'd0,          32'd0,          1'b1, 1};
        vecs[6]  = '{32'd9,          32'd3,          32'd3,          1'b0, 33};
        vecs[7]  = '{32'h80000000,   32'hFFFFFFFF,   32'h80000000,   1'b0, 33};
        vecs[8]  = '{32'h80000000,   32'd1,          32'h80000000,   1'b0, 33};
        vecs[9]  = '{32'd5,          32'd7,          32'd0,          1'b0, 33};
        vecs[10] = '{32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          1'b0, 33};
        vecs[11] = '{32'h7FFFFFFF,   32'h80000000,   32'd0,          1'b0, 33};
        vecs[12] = '{32'h80000000,   32'h80000000,   32'd1,          1'b0, 33};
        vecs[13] = '{32'h7FFFFFFF,   32'd1,          32'h7FFFFFFF,   1'b0, 33};
        vecs[14] = '{32'hFFFFFFF9,   32'd0,          32'd0,          1'b1, 1};

        reset_n = 1'b0;
        ctrl_DIV = 1'b0;
        data_operandA = 32'd0;
        data_operandB = 32'd0;
        #1;
        chk("reset result", data_result, 32'd0);
        chk("reset exception", {31'd0, data_exception}, 32'd0);
        chk("reset rdy", {31'd0, data_resultRDY}, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            run_div(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].exc, vecs[i].lat,
                    $sformatf("vec%0d", i));
        end

        // Back-to-back: new request sampled in the ready cycle of 20/4.
        lat = 0;
        @(negedge clock);
        ctrl_DIV = 1'b1;
        data_operandA = 32'd20;
        data_operandB = 32'd4;
        @(posedge clock);
        #1;
        ctrl_DIV = 1'b0;
        for (int n = 1; n <= 60 && lat == 0; n++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) lat = n;
        end
        chk("b2b first latency", 32'(lat), 32'd33);
        chk("b2b first result", data_result, 32'd5);
        ctrl_DIV = 1'b1;
        data_operandA = 32'd30;
        data_operandB = 32'd3;
        @(posedge clock);
        #1;
        ctrl_DIV = 1'b0;
        chk("b2b second busy", {31'd0, busy}, 32'd1);
        chk("b2b second rdy_low", {31'd0, data_resultRDY}, 32'd0);
        lat = 0;
        for (int n = 1; n <= 60 && lat == 0; n++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) lat = n;
        end
        chk("b2b second latency", 32'(lat), 32'd33);
        chk("b2b second result", data_result, 32'd10);
        @(posedge clock);
        #1;

        // Restart: 50/5 aborted by 81/9 at edge 10.
        early = 0;
        @(negedge clock);
        ctrl_DIV = 1'b1;
        data_operandA = 32'd50;
        data_operandB = 32'd5;
        @(posedge clock);
        #1;
        ctrl_DIV = 1'b0;
        for (int n = 1; n <= 9; n++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) early++;
        end
        ctrl_DIV = 1'b1;
        data_operandA = 32'd81;
        data_operandB = 32'd9;
        @(posedge clock);
        #1;
        ctrl_DIV = 1'b0;
        if (data_resultRDY) early++;
        lat = 0;
        for (int n = 1; n <= 60 && lat == 0; n++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) lat = n;
        end
        chk("restart no_early_rdy", 32'(early), 32'd0);
        chk("restart latency", 32'(lat), 32'd33);
        chk("restart result", data_result, 32'd9);
        @(posedge clock);
        #1;
        chk("restart rdy_single", {31'd0, data_resultRDY}, 32'd0);

        // Asynchronous reset in the middle of a divide.
        @(negedge clock);
        ctrl_DIV = 1'b1;
        data_operandA = 32'd1000;
        data_operandB = 32'd3;
        @(posedge clock);
        #1;
        ctrl_DIV = 1'b0;
        repeat (20) @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midreset result", data_result, 32'd0);
        chk("midreset exception", {31'd0, data_exception}, 32'd0);
        chk("midreset rdy", {31'd0, data_resultRDY}, 32'd0);
        chk("midreset busy", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        early = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) early++;
        end
        chk("midreset no_rdy_after_release", 32'(early), 32'd0);
        run_div(32'd7, 32'd2, 32'd3, 1'b0, 33, "post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
